wb_stream_reader: RTL

- Wishbone initiator that reads a contiguous block of 32-bit words from a Wishbone responder (the wb_memory SRAM front-end) and presents them as a valid/ready sample stream.
- Sits between the memory responder and waveform-generator datapaths, so stored waveforms can be replayed without CPU involvement.
- Single outstanding bus read; a small prefetch FIFO absorbs bus latency and consumer back-pressure.

---
 rtl/wb_stream_reader_pkg.sv | 14 +
 rtl/sync_fifo.sv | 66 ++++++
 rtl/wb_stream_reader.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/wb_stream_reader_pkg.sv
// Shared types and constants for the Wishbone stream reader.
package wb_stream_reader_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitAck,
    StFinish
  } state_e;

  localparam logic [3:0]  WB_SEL_ALL = 4'hF;
  localparam logic [31:0] WORD_BYTES = 32'd4;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered storage; dout is the current head entry.
// DEPTH must be a power of two (pointers wrap naturally), minimum 2.
// clr empties the FIFO without touching storage; push when full and pop when
// empty are ignored.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage, pointers and occupancy; simultaneous push/pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  // With a power-of-two depth the top count bit is set only when full.
  assign full  = count_q[PtrW];
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/wb_stream_reader.sv
// Wishbone read initiator: fetches a contiguous block of 32-bit words with a
// single outstanding read and presents them as a valid/ready stream through a
// small prefetch FIFO.
// Optional feature: define WB_STREAM_READER_LOOP_EN to replay the block
// endlessly until stop.
module wb_stream_reader
  import wb_stream_reader_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             io_wbs_clk,
  input  logic             io_wbs_rst,
  input  logic             start,
  input  logic             stop,
  input  logic [31:0]      base_addr,
  input  logic [CNT_W-1:0] num_words,
  output logic             busy,
  output logic             done,
  output logic [31:0]      io_wbm_adr,
  output logic [31:0]      io_wbm_datwr,
  input  logic [31:0]      io_wbm_datrd,
  output logic             io_wbm_we,
  output logic [3:0]       io_wbm_sel,
  output logic             io_wbm_stb,
  input  logic             io_wbm_ack,
  output logic             io_wbm_cyc,
  output logic [31:0]      data_o,
  output logic             valid_o,
  input  logic             ready_i
);

  localparam int unsigned       CountW   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CountW-1:0] DepthCnt = CountW'(FIFO_DEPTH);

  state_e           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      adr_q, adr_d;
  logic             stb_q, stb_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             stop_seen_q, stop_seen_d;
  logic             done_q, done_d;
  logic             zero_pend_q, zero_pend_d;
`ifdef WB_STREAM_READER_LOOP_EN
  logic [31:0]      base_q, base_d;
  logic [CNT_W-1:0] num_q, num_d;
`endif

  logic              fifo_push, fifo_clr;
  logic              fifo_full, fifo_empty;
  logic [CountW-1:0] fifo_count;
  logic              unused_base_lsbs;

  // Word alignment discards the byte-offset bits.
  assign unused_base_lsbs = ^base_addr[1:0];

  // Next-state, bus request and FIFO control.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    adr_d       = adr_q;
    stb_d       = stb_q;
    remaining_d = remaining_q;
    stop_seen_d = stop_seen_q;
    done_d      = 1'b0;
    zero_pend_d = 1'b0;
    fifo_push   = 1'b0;
    fifo_clr    = 1'b0;
`ifdef WB_STREAM_READER_LOOP_EN
    base_d      = base_q;
    num_d       = num_q;
`endif
    unique case (state_q)
      StIdle: begin
        // A zero-length request completes one cycle after it is seen.
        if (zero_pend_q) begin
          done_d = 1'b1;
        end
        if (start) begin
          if (num_words != '0) begin
            addr_d      = {base_addr[31:2], 2'b00};
            remaining_d = num_words;
            stop_seen_d = 1'b0;
            fifo_clr    = 1'b1;
            state_d     = StIssue;
`ifdef WB_STREAM_READER_LOOP_EN
            base_d      = {base_addr[31:2], 2'b00};
            num_d       = num_words;
`endif
          end else begin
            zero_pend_d = 1'b1;
          end
        end
      end
      StIssue: begin
        if (stop) begin
          state_d = StFinish;
        end else if (fifo_count < DepthCnt) begin
          // Only issue when the returning word is guaranteed a FIFO slot.
          stb_d   = 1'b1;
          adr_d   = addr_q;
          state_d = StWaitAck;
        end
      end
      StWaitAck: begin
        if (stop) begin
          stop_seen_d = 1'b1;
        end
        if (io_wbm_ack) begin
          fifo_push   = !fifo_full;
          stb_d       = 1'b0;
          addr_d      = addr_q + WORD_BYTES;
          remaining_d = remaining_q - CNT_W'(1);
          if (stop || stop_seen_q) begin
            state_d = StFinish;
          end else if (remaining_q == CNT_W'(1)) begin
`ifdef WB_STREAM_READER_LOOP_EN
            addr_d      = base_q;
            remaining_d = num_q;
            state_d     = StIssue;
`else
            state_d     = StFinish;
`endif
          end else begin
            state_d = StIssue;
          end
        end
      end
      StFinish: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        stb_d   = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge io_wbs_clk) begin
    if (io_wbs_rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      adr_q       <= '0;
      stb_q       <= 1'b0;
      remaining_q <= '0;
      stop_seen_q <= 1'b0;
      done_q      <= 1'b0;
      zero_pend_q <= 1'b0;
`ifdef WB_STREAM_READER_LOOP_EN
      base_q      <= '0;
      num_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      adr_q       <= adr_d;
      stb_q       <= stb_d;
      remaining_q <= remaining_d;
      stop_seen_q <= stop_seen_d;
      done_q      <= done_d;
      zero_pend_q <= zero_pend_d;
`ifdef WB_STREAM_READER_LOOP_EN
      base_q      <= base_d;
      num_q       <= num_d;
`endif
    end
  end

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (io_wbs_clk),
    .rst   (io_wbs_rst),
    .clr   (fifo_clr),
    .push  (fifo_push),
    .pop   (ready_i),
    .din   (io_wbm_datrd),
    .dout  (data_o),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign busy         = (state_q != StIdle);
  assign done         = done_q;
  assign io_wbm_adr   = adr_q;
  assign io_wbm_datwr = '0;
  assign io_wbm_we    = 1'b0;
  assign io_wbm_sel   = WB_SEL_ALL;
  assign io_wbm_stb   = stb_q;
  assign io_wbm_cyc   = stb_q;
  assign valid_o      = !fifo_empty;

endmodule
